// File: rtl/lsu_dmem_master.sv
// Load/store initiator for the single-port synchronous data SRAM: one request in flight,
// lane formatting, fixed-latency response. Define MISALIGN_SPLIT_EN to split misaligned accesses.
module lsu_dmem_master #(
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_data_addr,
  input  logic [31:0] i_data_rd_data,
  output logic [31:0] o_data_wr_data,
  output logic [3:0]  o_data_size,
  output logic        o_data_write,
  output logic        o_data_read
);

`ifdef MISALIGN_SPLIT_EN
  localparam int unsigned LANE_W = 8;
  localparam int unsigned WSH_W  = 64;
  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_DATA0, S_DATA1} state_e;
`else
  localparam int unsigned LANE_W = 4;
  localparam int unsigned WSH_W  = 32;
  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_DATA0} state_e;
`endif

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef MISALIGN_SPLIT_EN
  logic [31:0] low_q, low_d;
  logic        split_c;
`endif

  logic [1:0]        k;
  logic [4:0]        sh;
  logic [3:0]        base_mask;
  logic [1:0]        last_off;
  logic [32:0]       last_byte;
  logic              illegal_c, misalign_c, oor_c, err_c;
  logic [LANE_W-1:0] mask_sh;
  logic [WSH_W-1:0]  wdata_sh;
  logic [31:0]       ld_word, ld_ext;

  assign k  = addr_q[1:0];
  assign sh = {k, 3'b000};

  always_comb begin
    base_mask = 4'b0001;
    last_off  = 2'd0;
    case (f3_q[1:0])
      2'b01:   begin base_mask = 4'b0011; last_off = 2'd1; end
      2'b10:   begin base_mask = 4'b1111; last_off = 2'd3; end
      default: begin base_mask = 4'b0001; last_off = 2'd0; end
    endcase
  end

  assign illegal_c  = we_q ? (f3_q[2] || f3_q[1:0] == 2'b11)
                           : (f3_q == 3'b011 || f3_q[2:1] == 2'b11);
  assign misalign_c = (f3_q[1:0] == 2'b01 && k == 2'd3) || (f3_q[1:0] == 2'b10 && k != 2'd0);
  // Checking both first and last byte covers a split's second word as well as wrap past 2^32.
  assign last_byte  = {1'b0, addr_q} + {31'd0, last_off};
  assign oor_c      = ((addr_q >> MEM_ADDR_WIDTH) != '0) || ((last_byte >> MEM_ADDR_WIDTH) != '0);
`ifdef MISALIGN_SPLIT_EN
  assign err_c   = illegal_c || oor_c;
  assign split_c = misalign_c && !err_c;
`else
  assign err_c   = illegal_c || oor_c || misalign_c;
`endif

  assign mask_sh  = LANE_W'(base_mask) << k;
  assign wdata_sh = WSH_W'(wdata_q) << sh;

`ifdef MISALIGN_SPLIT_EN
  logic [63:0] ld_src;
  assign ld_src  = (state_q == S_DATA1) ? {i_data_rd_data, low_q} : {32'd0, i_data_rd_data};
  assign ld_word = ld_src[sh +: 32];
`else
  assign ld_word = i_data_rd_data >> sh;
`endif

  always_comb begin
    case (f3_q[1:0])
      2'b00:   ld_ext = {{24{~f3_q[2] & ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_ext = {{16{~f3_q[2] & ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  always_comb begin
    o_data_read    = 1'b0;
    o_data_write   = 1'b0;
    o_data_size    = '0;
    o_data_addr    = '0;
    o_data_wr_data = '0;
    o_rsp_valid    = 1'b0;
    if (state_q == S_ACC0 && !err_c) begin
      o_data_read    = ~we_q;
      o_data_write   = we_q;
      o_data_size    = mask_sh[3:0];
      o_data_addr    = {addr_q[31:2], 2'b00};
      o_data_wr_data = we_q ? wdata_sh[31:0] : '0;
    end
    if (state_q == S_DATA0) begin
`ifdef MISALIGN_SPLIT_EN
      if (split_c) begin
        o_data_read    = ~we_q;
        o_data_write   = we_q;
        o_data_size    = mask_sh[7:4];
        o_data_addr    = {addr_q[31:2] + 30'd1, 2'b00};
        o_data_wr_data = we_q ? wdata_sh[63:32] : '0;
      end else
`endif
      o_rsp_valid = 1'b1;
    end
`ifdef MISALIGN_SPLIT_EN
    if (state_q == S_DATA1) o_rsp_valid = 1'b1;
`endif
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_err   = o_rsp_valid && err_c;
  assign o_rsp_rdata = (o_rsp_valid && !we_q && !err_c) ? ld_ext : '0;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MISALIGN_SPLIT_EN
    low_d   = low_q;
`endif
    case (state_q)
      S_IDLE: if (i_req_valid) begin
        state_d = S_ACC0;
        we_d    = i_req_we;
        f3_d    = i_req_funct3;
        addr_d  = i_req_addr;
        wdata_d = i_req_wdata;
      end
      S_ACC0: state_d = S_DATA0;
      S_DATA0: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_c) begin
          state_d = S_DATA1;
          low_d   = i_data_rd_data;
        end else
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
      low_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MISALIGN_SPLIT_EN
      low_q   <= low_d;
`endif
    end
  end

endmodule
